// File: rtl/ctrl_word_fifo.sv
// ctrl_word_fifo: registered queue between the ALU control decoder and the
// execute stage. Holds up to DEPTH (opcode, control word) pairs in order and
// screens each incoming word for the decoder invariant (bit 23 set). Words
// that break the invariant are consumed but not stored. They also raise a
// sticky error flag and bump a saturating drop counter.
module ctrl_word_fifo #(
    parameter int DEPTH = 4,
    parameter int OPW   = 7,
    parameter int CW    = 26
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPW-1:0]           in_op,
    input  logic [CW-1:0]            in_cw,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPW-1:0]           out_op,
    output logic [CW-1:0]            out_cw,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err_sticky,
    input  logic                     err_clr,
    output logic [7:0]               drop_cnt
);

    localparam int AW     = $clog2(DEPTH);
    localparam int LW     = AW + 1;
    localparam int OK_BIT = 23;   // decoder always sets this bit in a legal word

    // Storage array plus the bookkeeping registers.
    logic [OPW-1:0] mem_op [DEPTH];
    logic [CW-1:0]  mem_cw [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  count;

    // Per-cycle handshake decode.
    logic push_hs;
    logic push_store;
    logic reject;
    logic pop;

    // Status outputs come from registers only. Status never depends on the
    // request inputs.
    assign in_ready  = (count != LW'(DEPTH));
    assign out_valid = (count != '0);
    assign level     = count;
    assign out_op    = out_valid ? mem_op[rd_ptr] : '0;
    assign out_cw    = out_valid ? mem_cw[rd_ptr] : '0;

    // Classify this cycle's transfers. Flush discards both the push and the pop.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
        push_hs    = in_valid & in_ready;
        push_store = 1'b0;
        reject     = 1'b0;
        pop        = 1'b0;
        if (!flush) begin
            push_store = push_hs &  in_cw[OK_BIT];
            reject     = push_hs & ~in_cw[OK_BIT];
            pop        = out_valid & out_ready;
        end
    end

    // Write and read pointers wrap naturally at DEPTH (a power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_store) wr_ptr <= wr_ptr + AW'(1);
            if (pop)        rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Occupancy: a simultaneous store and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push_store, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Error tracking. A rejection in the same cycle outranks err_clr, and
    // only reset clears drop_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (reject)       err_sticky <= 1'b1;
            else if (err_clr) err_sticky <= 1'b0;
            if (reject && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Entry storage. A slot is only read after it has been written.
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately left out of reset; count gates every read, so stale contents are never visible.
        if (push_store) begin
            mem_op[wr_ptr] <= in_op;
            mem_cw[wr_ptr] <= in_cw;
        end
    end

endmodule
